// File: rtl/fpu_scheduler.sv
// fpu_scheduler: arbitrates two requesters onto one combinational FPU; define FPU_SCHED_RR_EN for round-robin, else fixed priority to requester 0.
module fpu_scheduler #(
    parameter int EXEC_CYCLES = 2
) (
    input  logic        CLK,
    input  logic        RSTn,
    input  logic        Req0Valid,
    input  logic        Req1Valid,
    output logic        Req0Ready,
    output logic        Req1Ready,
    input  logic [1:0]  Req0Op,
    input  logic [1:0]  Req1Op,
    input  logic [31:0] Req0A,
    input  logic [31:0] Req0B,
    input  logic [31:0] Req1A,
    input  logic [31:0] Req1B,
    output logic [1:0]  FpuOp,
    output logic [31:0] FpuOperand1,
    output logic [31:0] FpuOperand2,
    input  logic [31:0] FpuResult,
    output logic        RespValid,
    input  logic        RespReady,
    output logic [31:0] RespResult,
    output logic        RespId,
    output logic        Busy
);
    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        last_id_q, last_id_d, id_q, id_d;
    logic [1:0]  op_q, op_d;
    logic [31:0] a_q, a_d, b_q, b_d, res_q, res_d;
    logic        gnt_id, idle;
    assign idle = state_q == IDLE;
`ifdef FPU_SCHED_RR_EN
    assign gnt_id = (Req0Valid && Req1Valid) ? ~last_id_q : Req1Valid;
`else
    assign gnt_id = !Req0Valid;
`endif
    assign Req0Ready   = idle && Req0Valid && !gnt_id;
    assign Req1Ready   = idle && Req1Valid && gnt_id;
    assign FpuOp       = op_q;
    assign FpuOperand1 = a_q;
    assign FpuOperand2 = b_q;
    assign RespValid   = state_q == DONE;
    assign RespResult  = res_q;
    assign RespId      = id_q;
    assign Busy        = !idle;
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        last_id_d = last_id_q;
        id_d      = id_q;
        op_d      = op_q;
        a_d       = a_q;
        b_d       = b_q;
        res_d     = res_q;
        case (state_q)
            IDLE: if (Req0Valid || Req1Valid) begin
                state_d   = EXEC;
                cnt_d     = 4'(EXEC_CYCLES - 1);
                last_id_d = gnt_id;
                id_d      = gnt_id;
                op_d      = gnt_id ? Req1Op : Req0Op;
                a_d       = gnt_id ? Req1A : Req0A;
                b_d       = gnt_id ? Req1B : Req0B;
            end
            EXEC: if (cnt_q == 4'd0) begin
                state_d = DONE;
                res_d   = FpuResult;
            end else begin
                cnt_d = cnt_q - 4'd1;
            end
            DONE: state_d = RespReady ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            last_id_q <= 1'b1;
            id_q      <= 1'b0;
            op_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            res_q     <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            last_id_q <= last_id_d;
            id_q      <= id_d;
            op_q      <= op_d;
            a_q       <= a_d;
            b_q       <= b_d;
            res_q     <= res_d;
        end
    end
endmodule

// File: tb/tb_fpu_scheduler.sv
// tb_fpu_scheduler: directed bench for fpu_scheduler with a stand-in XOR FPU; honours FPU_SCHED_RR_EN.
module tb_fpu_scheduler;
    logic        CLK, RSTn;
    logic        r0v, r1v, RespReady;
    logic [1:0]  r0op, r1op;
    logic [31:0] r0a, r0b, r1a, r1b;
    logic        Req0Ready, Req1Ready, RespValid, RespId, Busy;
    logic [1:0]  FpuOp;
    logic [31:0] FpuOperand1, FpuOperand2, FpuResult, RespResult;
    int checks = 0;
    int errors = 0;
    logic exp_id;

    fpu_scheduler #(.EXEC_CYCLES(2)) dut (
        .CLK(CLK), .RSTn(RSTn),
        .Req0Valid(r0v), .Req1Valid(r1v),
        .Req0Ready(Req0Ready), .Req1Ready(Req1Ready),
        .Req0Op(r0op), .Req1Op(r1op),
        .Req0A(r0a), .Req0B(r0b), .Req1A(r1a), .Req1B(r1b),
        .FpuOp(FpuOp), .FpuOperand1(FpuOperand1), .FpuOperand2(FpuOperand2),
        .FpuResult(FpuResult),
        .RespValid(RespValid), .RespReady(RespReady),
        .RespResult(RespResult), .RespId(RespId), .Busy(Busy)
    );

    assign FpuResult = FpuOperand1 ^ FpuOperand2 ^ {30'd0, FpuOp};

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_r0rdy"}, Req0Ready, 0);
        chk({tag, "_r1rdy"}, Req1Ready, 0);
        chk({tag, "_op"}, FpuOp, 0);
        chk({tag, "_a"}, FpuOperand1, 0);
        chk({tag, "_b"}, FpuOperand2, 0);
        chk({tag, "_rvalid"}, RespValid, 0);
        chk({tag, "_rres"}, RespResult, 0);
        chk({tag, "_rid"}, RespId, 0);
        chk({tag, "_busy"}, Busy, 0);
    endtask

    initial begin
        RSTn = 1'b0; r0v = 0; r1v = 0; RespReady = 1;
        r0op = 0; r1op = 0; r0a = 0; r0b = 0; r1a = 0; r1b = 0;
        #1;
        chk_reset_outs("reset");
        tick(); tick();
        RSTn = 1'b1;
        tick();

        // single request from requester 0
        r0v = 1; r0op = 2'd0; r0a = 32'h3F800000; r0b = 32'h40000000;
        #1;
        chk("single_r0rdy", Req0Ready, 1);
        chk("single_r1rdy", Req1Ready, 0);
        chk("single_idle_busy", Busy, 0);
        tick();
        r0v = 0;
        chk("single_c1_busy", Busy, 1);
        chk("single_c1_rvalid", RespValid, 0);
        chk("single_c1_op", FpuOp, 0);
        chk("single_c1_a", FpuOperand1, 32'h3F800000);
        chk("single_c1_b", FpuOperand2, 32'h40000000);
        tick();
        chk("single_c2_rvalid", RespValid, 0);
        chk("single_c2_busy", Busy, 1);
        tick();
        chk("single_c3_rvalid", RespValid, 1);
        chk("single_c3_res", RespResult, 32'h7F800000);
        chk("single_c3_id", RespId, 0);
        chk("single_c3_busy", Busy, 1);
        tick();
        chk("single_c4_busy", Busy, 0);
        chk("single_c4_rvalid", RespValid, 0);

        // requester 1 with backpressure and operand changes during EXEC
        RespReady = 0;
        r1v = 1; r1op = 2'd2; r1a = 32'h40400000; r1b = 32'h40800000;
        #1;
        chk("bp_r1rdy", Req1Ready, 1);
        chk("bp_r0rdy", Req0Ready, 0);
        tick();
        r1op = 2'd1; r1a = 32'h0; r1b = 32'hFFFFFFFF;
        r0v = 1; r0op = 2'd3; r0a = 32'h12345678; r0b = 32'h9ABCDEF0;
        #1;
        chk("bp_c1_r0rdy", Req0Ready, 0);
        chk("bp_c1_r1rdy", Req1Ready, 0);
        chk("bp_c1_a", FpuOperand1, 32'h40400000);
        tick();
        chk("bp_c2_b", FpuOperand2, 32'h40800000);
        chk("bp_c2_op", FpuOp, 2);
        tick();
        chk("bp_c3_rvalid", RespValid, 1);
        chk("bp_c3_res", RespResult, 32'h00C00002);
        chk("bp_c3_id", RespId, 1);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("bp_hold_rvalid", RespValid, 1);
            chk("bp_hold_res", RespResult, 32'h00C00002);
            chk("bp_hold_id", RespId, 1);
            chk("bp_hold_r0rdy", Req0Ready, 0);
            chk("bp_hold_r1rdy", Req1Ready, 0);
            chk("bp_hold_busy", Busy, 1);
        end
        r0v = 0; r1v = 0; RespReady = 1;
        #1;
        chk("bp_release_rvalid", RespValid, 1);
        tick();
        chk("bp_idle_busy", Busy, 0);
        chk("bp_idle_rvalid", RespValid, 0);
        chk("bp_idle_keep_a", FpuOperand1, 32'h40400000);
        chk("bp_idle_keep_op", FpuOp, 2);

        // continuous conflict: last grant was requester 1
        r0op = 2'd1; r0a = 32'h1;  r0b = 32'h2;
        r1op = 2'd3; r1a = 32'h10; r1b = 32'h20;
        r0v = 1; r1v = 1;
        for (int i = 0; i < 4; i++) begin
`ifdef FPU_SCHED_RR_EN
            exp_id = i[0];
`else
            exp_id = 1'b0;
`endif
            #1;
            chk("conf_r0rdy", Req0Ready, !exp_id);
            chk("conf_r1rdy", Req1Ready, exp_id);
            tick(); tick(); tick();
            chk("conf_rvalid", RespValid, 1);
            chk("conf_id", RespId, exp_id);
            chk("conf_res", RespResult, exp_id ? 32'h33 : 32'h2);
            tick();
        end
        r0v = 0; r1v = 0;

        // reset in the first EXEC cycle
        r0v = 1; r0op = 2'd0; r0a = 32'h5; r0b = 32'h3;
        tick();
        r0v = 0;
        RSTn = 1'b0;
        #1;
        chk_reset_outs("midrst");
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("midrst_rvalid", RespValid, 0);
            chk("midrst_busy", Busy, 0);
        end
        RSTn = 1'b1;
        tick();
        r0v = 1; r1v = 1; r0op = 2'd1; r0a = 32'h11; r0b = 32'h22;
        #1;
        chk("post_r0rdy", Req0Ready, 1);
        chk("post_r1rdy", Req1Ready, 0);
        tick();
        r0v = 0; r1v = 0;
        tick(); tick();
        chk("post_rvalid", RespValid, 1);
        chk("post_res", RespResult, 32'h32);
        chk("post_id", RespId, 0);
        tick();
        chk("post_busy", Busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fpu_scheduler.md
# fpu_scheduler

Shares the single combinational FPU between two requesters, the integer-issue port (requester 0) and the load/store replay port (requester 1). It arbitrates between their valid/ready requests and latches the winning operands onto the FPU inputs. It holds them stable for a programmable settle time, captures the FPU result, and returns the result with the requester ID over a valid/ready response channel. The FPU itself stays purely combinational; this block is the only driver of its inputs.

## Interface
- `EXEC_CYCLES`, 2: cycles the FPU inputs are held stable before the result is sampled; legal range 1–15.
- `CLK`  in  1  system clock; all state updates on the rising edge.
- `RSTn`  in  1  reset, asynchronous, active-low.
- `Req0Valid`, `Req1Valid`  in  1  requester N has an operation pending.
- `Req0Ready`, `Req1Ready`  out  1  requester N's operation is accepted this cycle.
- `Req0Op`, `Req1Op`  in  2  FPU opcode, passed through to `FpuOp`.
- `Req0A`, `Req0B`, `Req1A`, `Req1B`  in  32  IEEE-754 single-precision operands.
- `FpuOp`  out  2  registered opcode to the FPU.
- `FpuOperand1`, `FpuOperand2`  out  32  registered operands to the FPU.
- `FpuResult`  in  32  combinational result from the FPU.
- `RespValid`  out  1  response available.
- `RespReady`  in  1  consumer takes the response.
- `RespResult`  out  32  captured FPU result.
- `RespId`  out  1  requester that issued the operation.
- `Busy`  out  1  high whenever the state is not IDLE.

## Operation
- **States:** IDLE, EXEC, DONE. Reset forces IDLE.
- **IDLE**
  - If any `ReqNValid` is high, the grant goes to one requester and its `ReqNReady` is driven high combinationally in the same cycle. `ReqNReady` is never high outside IDLE, and never high for both requesters at once.
  - On the handshake edge, the block latches Op/A/B into `FpuOp`/`FpuOperand1`/`FpuOperand2`, latches the ID into `RespId`, loads the counter with `EXEC_CYCLES-1`, and moves to EXEC.
- **EXEC**
  - FPU inputs are held constant and the counter decrements once per cycle.
  - In the cycle the counter reads 0, the block captures `FpuResult` into `RespResult` and moves to DONE.
- **DONE**
  - `RespValid`=1. `RespResult` and `RespId` stay stable until `RespValid && RespReady`, which returns the FSM to IDLE.
  - No new request is accepted in the same cycle as the response handshake.
- **Arbitration:** a `LastId` register is updated on each grant and resets to 1, so requester 0 wins the first conflict. Policy is set by the Configuration macro.
- **Outputs:** the FPU input registers keep their last values after the operation completes. They are not cleared in IDLE.
- **Reset values:** `Req0Ready`=`Req1Ready`=0 (combinational, in IDLE with no valid), `FpuOp`=0, `FpuOperand1`=`FpuOperand2`=0, `RespValid`=0, `RespResult`=0, `RespId`=0, `Busy`=0.
- **Reset mid-operation:** asynchronous clear to IDLE. The in-flight operation is dropped and no response is produced.
- **Requester rules:** a requester must hold Valid/Op/A/B stable until it sees Ready. Deasserting Valid before Ready is allowed; that request is simply not granted.

## Timing
- Handshake at edge 0. EXEC occupies cycles 1…`EXEC_CYCLES`. `RespValid` rises in cycle `EXEC_CYCLES`+1.
- Request-to-response latency is `EXEC_CYCLES`+1 cycles.
- With `RespReady` held at 1, the minimum issue interval is `EXEC_CYCLES`+2 cycles.
- `ReqNReady` depends combinationally on `ReqNValid` and state only. It does not depend on `RespReady`.
- `FpuResult` must settle within `EXEC_CYCLES` clock periods of the operand registers changing; meeting this is the integrator's responsibility when choosing `EXEC_CYCLES`.

## Configuration
- **`FPU_SCHED_RR_EN`**
  - Defined: round-robin. When both requesters are valid, the one not equal to `LastId` wins. A single valid requester always wins.
  - Undefined: fixed priority, with requester 0 always winning a conflict. `LastId` is still updated but has no effect.

## Test plan
- **Single request:** `EXEC_CYCLES`=2, requester 0 sends Op=0, A=0x3F800000, B=0x40000000, with `RespReady`=1 → `Req0Ready` is high at edge 0; `RespValid` is high in cycle 3 with `RespResult` = the FPU output for those operands and `RespId`=0; `Busy` is high in cycles 1–3.
- **Conflict, `FPU_SCHED_RR_EN` defined:** both requesters valid continuously → grants alternate 0, 1, 0, 1 and `RespId` alternates accordingly.
- **Conflict, macro undefined:** the same stimulus → only requester 0 is granted while it stays valid.
- **Response backpressure:** `RespReady`=0 for 5 cycles after `RespValid` rises → `RespResult`/`RespId` stay stable; both `ReqNReady` stay 0; IDLE is reached one cycle after `RespReady` goes high.
- **Reset mid-operation:** `RSTn` pulled low in cycle 1 of EXEC → all outputs take their reset values immediately; no `RespValid` follows; the next request proceeds normally.
- **Operand stability:** requester inputs change during EXEC → `FpuOperand1`/`FpuOperand2`/`FpuOp` stay unchanged until the next grant.
